// File: rtl/imem_loader_pkg.sv
// ==================================================================
// Module : imem_loader_pkg
// Brief  : shared types and helpers for the instruction-memory loader
// Rev    : 1.0
// ==================================================================
`default_nettype none

package imem_loader_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} loader_state_t;

  localparam int DEFAULT_WORD_SIZE = 32;
  localparam int BYTES_PER_WORD    = DEFAULT_WORD_SIZE / 8;

  function automatic int bytes_per_word(input int word_size);
    return word_size / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader_if.sv
// ==================================================================
// Module : imem_loader_if
// Brief  : host stream, control and memory write port of the loader
// Rev    : 1.0
// ==================================================================
`default_nettype none

interface imem_loader_if #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_BITS = 32
);
  logic                 start;
  logic [ADDR_BITS-1:0] word_count;
  logic [7:0]           byte_in;
  logic                 byte_valid;
  logic                 byte_ready;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [WORD_SIZE-1:0] wr_data;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic                 cpu_hold;

  modport master (
    output start, word_count, byte_in, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data, busy, done, err, cpu_hold
  );

  modport slave (
    input  start, word_count, byte_in, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data, busy, done, err, cpu_hold
  );
endinterface

`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
// ==================================================================
// Module : word_assembler
// Brief  : packs accepted bytes little-endian into one word
// Rev    : 1.0
// ==================================================================
`default_nettype none

module word_assembler
  import imem_loader_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clear,
  input  logic [7:0]           i_byte,
  input  logic                 i_byte_valid,
  output logic [WORD_SIZE-1:0] o_word,
  output logic                 o_word_valid
);
  localparam int c_BPW   = bytes_per_word(WORD_SIZE);
  localparam int c_IDX_W = (c_BPW > 1) ? $clog2(c_BPW) : 1;

  logic [c_IDX_W-1:0]   r_idx;
  logic [WORD_SIZE-1:0] r_bytes;
  logic [WORD_SIZE-1:0] w_word;
  logic                 w_last;

  // The word including the byte arriving this cycle, so the top can register it directly.
  always_comb begin
    w_word = r_bytes;
    for (int k = 0; k < c_BPW; k++) begin
      if (r_idx == c_IDX_W'(k)) w_word[8*k +: 8] = i_byte;
    end
  end

  assign w_last = i_byte_valid && (r_idx == c_IDX_W'(c_BPW - 1));

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_idx   <= '0;
      r_bytes <= '0;
    end else if (i_byte_valid) begin
      r_bytes <= w_word;
      r_idx   <= w_last ? '0 : r_idx + c_IDX_W'(1);
    end
  end

  assign o_word       = w_word;
  assign o_word_valid = w_last;

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ==================================================================
// Module : imem_loader
// Brief  : fills instruction memory from a byte stream, then releases the core
// Rev    : 1.0
// ==================================================================
`default_nettype none

module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_BITS = 32,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  imem_loader_if.slave      bus
);
  loader_state_t        r_state, w_next;
  logic [ADDR_BITS-1:0] r_count, r_word_idx;
  logic [ADDR_BITS-1:0] r_wr_addr;
  logic [WORD_SIZE-1:0] r_wr_data;
  logic                 r_wr_en, r_busy, r_done, r_err, r_cpu_hold;
  logic                 w_start_ok, w_byte_acc, w_word_valid, w_final, w_too_big;
  logic                 w_err_nxt, w_hold_nxt;
  logic [WORD_SIZE-1:0] w_word;

  assign w_start_ok = bus.start && (r_state != LOAD);
  assign w_byte_acc = bus.byte_valid && (r_state == LOAD);
  assign w_too_big  = bus.word_count > ADDR_BITS'(MEM_DEPTH);
  assign w_final    = w_word_valid && (r_word_idx == r_count - ADDR_BITS'(1));

  word_assembler #(.WORD_SIZE(WORD_SIZE)) u_asm (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_start_ok),
    .i_byte       (bus.byte_in),
    .i_byte_valid (w_byte_acc),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (bus.start) begin
          if (bus.word_count == '0 || w_too_big) w_next = DONE;
          else                                   w_next = LOAD;
        end
      end
      LOAD:    if (w_final) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  // Next values for the registered status outputs; err only changes on an accepted start.
  always_comb begin
    w_err_nxt = r_err;
    if (w_start_ok) w_err_nxt = w_too_big;
    w_hold_nxt = !((w_next == DONE) && !w_err_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_word_idx <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_cpu_hold <= 1'b1;
    end else begin
      if (w_start_ok) begin
        r_count    <= bus.word_count;
        r_word_idx <= '0;
      end else if (w_word_valid) begin
        r_word_idx <= r_word_idx + ADDR_BITS'(1);
      end
      r_wr_en <= w_word_valid;
      if (w_word_valid) begin
        r_wr_addr <= r_word_idx;
        r_wr_data <= w_word;
      end
      r_busy     <= (w_next == LOAD);
      r_done     <= (w_next == DONE);
      r_err      <= w_err_nxt;
      r_cpu_hold <= w_hold_nxt;
    end
  end

  assign bus.byte_ready = (r_state == LOAD);
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.cpu_hold   = r_cpu_hold;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ==================================================================
// Module : tb_imem_loader
// Brief  : scoreboard bench for imem_loader with memory readback
// Rev    : 1.0
// ==================================================================
`default_nettype none

module tb_imem_loader;
  localparam int WS = 32;
  localparam int AB = 32;
  localparam int MD = 256;

  typedef struct {
    logic [AB-1:0] addr;
    logic [WS-1:0] data;
    logic          last;
  } wr_item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_loader_if #(.WORD_SIZE(WS), .ADDR_BITS(AB)) bus ();

  imem_loader #(.WORD_SIZE(WS), .ADDR_BITS(AB), .MEM_DEPTH(MD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  wr_item_t      exp_q[$];
  logic [WS-1:0] mem [0:MD-1];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_writes = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: every write strobe is matched against the oldest expected write.
  always @(negedge clk) begin
    if (bus.wr_en) begin
      wr_item_t e;
      n_writes++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", bus.wr_addr, bus.wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr",  64'(bus.wr_addr),  64'(e.addr));
        chk("wr_data",  64'(bus.wr_data),  64'(e.data));
        chk("wr_done",  64'(bus.done),     64'(e.last));
        chk("wr_hold",  64'(bus.cpu_hold), 64'(!e.last));
      end
      if (bus.wr_addr < AB'(MD)) mem[bus.wr_addr[7:0]] = bus.wr_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AB-1:0] a, input logic [WS-1:0] d, input logic l);
    wr_item_t e;
    e.addr = a; e.data = d; e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic start_load(input logic [AB-1:0] cnt);
    bus.start = 1'b1;
    bus.word_count = cnt;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.byte_in = b;
    bus.byte_valid = 1'b1;
    @(negedge clk);
    while (!bus.byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.byte_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic check_reset_values();
    @(negedge clk);
    chk("rst_byte_ready", 64'(bus.byte_ready), 64'(0));
    chk("rst_wr_en",      64'(bus.wr_en),      64'(0));
    chk("rst_wr_addr",    64'(bus.wr_addr),    64'(0));
    chk("rst_wr_data",    64'(bus.wr_data),    64'(0));
    chk("rst_busy",       64'(bus.busy),       64'(0));
    chk("rst_done",       64'(bus.done),       64'(0));
    chk("rst_err",        64'(bus.err),        64'(0));
    chk("rst_cpu_hold",   64'(bus.cpu_hold),   64'(1));
  endtask

  task automatic drain(input string name);
    repeat (3) tick();
    chk(name, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int w0;
    bus.start = 1'b0;
    bus.word_count = '0;
    bus.byte_in = '0;
    bus.byte_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    check_reset_values();
    tick();

    // 1: three words, back-to-back bytes
    push(0, 32'h03020100, 0);
    push(1, 32'h07060504, 0);
    push(2, 32'h0B0A0908, 1);
    start_load(3);
    for (int i = 0; i < 12; i++) send_byte(8'(i));
    drain("s1_queue");
    chk("s1_writes",     64'(n_writes),       64'(3));
    chk("s1_done",       64'(bus.done),       64'(1));
    chk("s1_byte_ready", 64'(bus.byte_ready), 64'(0));

    // 2: two words, byte_valid on every other cycle
    w0 = n_writes;
    push(0, 32'h03020100, 0);
    push(1, 32'h07060504, 1);
    start_load(2);
    for (int i = 0; i < 8; i++) begin
      send_byte(8'(i));
      tick();
    end
    drain("s2_queue");
    chk("s2_writes", 64'(n_writes - w0), 64'(2));

    // 3: zero count and oversize count
    w0 = n_writes;
    start_load(0);
    @(negedge clk);
    chk("s3a_done", 64'(bus.done),     64'(1));
    chk("s3a_err",  64'(bus.err),      64'(0));
    chk("s3a_hold", 64'(bus.cpu_hold), 64'(0));
    chk("s3a_busy", 64'(bus.busy),     64'(0));
    tick();
    start_load(AB'(MD + 1));
    @(negedge clk);
    chk("s3b_done",       64'(bus.done),       64'(1));
    chk("s3b_err",        64'(bus.err),        64'(1));
    chk("s3b_hold",       64'(bus.cpu_hold),   64'(1));
    chk("s3b_byte_ready", 64'(bus.byte_ready), 64'(0));
    repeat (3) tick();
    chk("s3_writes", 64'(n_writes - w0), 64'(0));

    // 4: reset mid-load, then a fresh one-word load
    w0 = n_writes;
    push(0, 32'h03020100, 0);
    start_load(2);
    for (int i = 0; i < 6; i++) send_byte(8'(i));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values();
    repeat (4) tick();
    chk("s4_queue",  64'(exp_q.size()),   64'(0));
    chk("s4_writes", 64'(n_writes - w0),  64'(1));
    push(0, 32'hDDCCBBAA, 1);
    start_load(1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    drain("s4b_queue");

    // 5: start during LOAD is ignored
    w0 = n_writes;
    push(0, 32'h13121110, 0);
    push(1, 32'h17161514, 0);
    push(2, 32'h1B1A1918, 1);
    start_load(3);
    for (int i = 0; i < 4; i++) send_byte(8'(8'h10 + i));
    start_load(1);
    @(negedge clk);
    chk("s5_busy", 64'(bus.busy), 64'(1));
    tick();
    for (int i = 4; i < 12; i++) send_byte(8'(8'h10 + i));
    drain("s5_queue");
    chk("s5_writes", 64'(n_writes - w0), 64'(3));

    // 6: full-depth load followed by memory readback sweep
    w0 = n_writes;
    for (int a = 0; a < MD; a++)
      push(AB'(a), {8'(4*a+3), 8'(4*a+2), 8'(4*a+1), 8'(4*a)}, a == MD - 1);
    start_load(AB'(MD));
    for (int i = 0; i < 4*MD; i++) send_byte(8'(i));
    drain("s6_queue");
    chk("s6_writes",    64'(n_writes - w0), 64'(MD));
    chk("s6_last_addr", 64'(bus.wr_addr),   64'(MD - 1));
    chk("s6_done",      64'(bus.done),      64'(1));
    for (int a = 0; a < MD; a++)
      chk("s6_readback", 64'(mem[a]), 64'({8'(4*a+3), 8'(4*a+2), 8'(4*a+1), 8'(4*a)}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
